// File: rtl/bus_arb2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arb2_pkg
// Purpose  : Shared state and region encodings for the two-master bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bus_arb2_pkg;

    localparam logic [1:0] c_s_idle   = 2'd0;
    localparam logic [1:0] c_s_decode = 2'd1;
    localparam logic [1:0] c_s_wait   = 2'd2;
    localparam logic [1:0] c_s_done   = 2'd3;

    localparam logic [1:0] c_r_none   = 2'd0;
    localparam logic [1:0] c_r_mem    = 2'd1;
    localparam logic [1:0] c_r_io     = 2'd2;
    localparam logic [1:0] c_r_simif  = 2'd3;

    // The simulator interface sits on top of the last IO block, so it must win.
    function automatic logic [1:0] region_of(input logic        cs_mem,
                                             input logic [15:0] cs_io,
                                             input logic        cs_simif);
        logic [1:0] w_r;
        if (cs_simif)
            w_r = c_r_simif;
        else if (|cs_io)
            w_r = c_r_io;
        else if (cs_mem)
            w_r = c_r_mem;
        else
            w_r = c_r_none;
        return w_r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr2
// Purpose  : Two-requester round-robin picker with a registered last grant.
// Revision : 1.0 - initial release
// ============================================================================
module arb_rr2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_winner,
    output logic       o_last_grant
);

    logic r_last;
    logic w_winner;

    // Contention goes to whoever did not own the previous cycle.
    always_comb begin
        if (i_req[0] && i_req[1])
            w_winner = ~r_last;
        else
            w_winner = i_req[1];
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_last <= 1'b1;
        else if (i_accept)
            r_last <= w_winner;
    end

    assign o_winner     = w_winner;
    assign o_last_grant = r_last;

endmodule
`default_nettype wire

// File: rtl/bus_arb2.sv
`default_nettype none
// ============================================================================
// Module   : bus_arb2
// Purpose  : Two-master round-robin bus arbiter and cycle sequencer with
//            per-region wait states and ready/err completion pulses.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arb2 #(
    parameter int MEM_ADDR_SIZE = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_WAIT      = 0,
    parameter int IO_WAIT       = 2,
    parameter int SIMIF_WAIT    = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     m0_req,
    input  logic [MEM_ADDR_SIZE-1:0] m0_addr,
    input  logic [DATA_W-1:0]        m0_wdata,
    input  logic                     m0_wen,
    output logic                     m0_ready,
    output logic                     m0_err,
    input  logic                     m1_req,
    input  logic [MEM_ADDR_SIZE-1:0] m1_addr,
    input  logic [DATA_W-1:0]        m1_wdata,
    input  logic                     m1_wen,
    output logic                     m1_ready,
    output logic                     m1_err,
    output logic [DATA_W-1:0]        m_rdata,
    output logic [MEM_ADDR_SIZE-1:0] bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    output logic                     bus_wen,
    input  logic [DATA_W-1:0]        bus_rdata,
    input  logic                     cs_mem,
    input  logic [15:0]              cs_io,
    input  logic                     cs_simif,
    output logic                     grant
);

    import bus_arb2_pkg::*;

    localparam logic [3:0] c_mem_wait   = 4'(MEM_WAIT);
    localparam logic [3:0] c_io_wait    = 4'(IO_WAIT);
    localparam logic [3:0] c_simif_wait = 4'(SIMIF_WAIT);

    logic [1:0]               r_state;
    logic [1:0]               w_next_state;
    logic [3:0]               r_cnt;
    logic [3:0]               w_next_cnt;
    logic                     r_err;
    logic                     w_next_err;
    logic                     r_wen;
    logic [MEM_ADDR_SIZE-1:0] r_addr;
    logic [DATA_W-1:0]        r_wdata;
    logic                     w_accept;
    logic                     w_winner;
    logic                     w_grant;
    logic [1:0]               w_region;
    logic [3:0]               w_region_wait;
    logic                     w_done_ok;
    logic                     w_done_err;

    arb_rr2 u_arb (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_req        ({m1_req, m0_req}),
        .i_accept     (w_accept),
        .o_winner     (w_winner),
        .o_last_grant (w_grant)
    );

    always_comb begin
        w_region      = region_of(cs_mem, cs_io, cs_simif);
        w_region_wait = 4'd0;
        case (w_region)
            c_r_mem:   w_region_wait = c_mem_wait;
            c_r_io:    w_region_wait = c_io_wait;
            c_r_simif: w_region_wait = c_simif_wait;
            default:   w_region_wait = 4'd0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_err   = r_err;
        w_accept     = 1'b0;
        case (r_state)
            c_s_idle: begin
                if (m0_req || m1_req) begin
                    w_accept     = 1'b1;
                    w_next_state = c_s_decode;
                end
            end
            c_s_decode: begin
                if (w_region == c_r_none) begin
                    w_next_err   = 1'b1;
                    w_next_state = c_s_done;
                end else begin
                    w_next_err   = 1'b0;
                    w_next_cnt   = w_region_wait;
                    w_next_state = (w_region_wait == 4'd0) ? c_s_done : c_s_wait;
                end
            end
            c_s_wait: begin
                w_next_cnt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1)
                    w_next_state = c_s_done;
            end
            default: begin
                w_next_state = c_s_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_s_idle;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_err   <= w_next_err;
            if (w_accept) begin
                r_addr  <= w_winner ? m1_addr  : m0_addr;
                r_wdata <= w_winner ? m1_wdata : m0_wdata;
                r_wen   <= w_winner ? m1_wen   : m0_wen;
            end
        end
    end

    assign w_done_ok  = (r_state == c_s_done) && !r_err;
    assign w_done_err = (r_state == c_s_done) &&  r_err;

    assign m0_ready  = w_done_ok  && !w_grant;
    assign m1_ready  = w_done_ok  &&  w_grant;
    assign m0_err    = w_done_err && !w_grant;
    assign m1_err    = w_done_err &&  w_grant;
    assign bus_wen   = w_done_ok  &&  r_wen;
    assign m_rdata   = bus_rdata;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign grant     = w_grant;

endmodule
`default_nettype wire

// File: tb/tb_bus_arb2.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arb2
// Purpose  : Self-checking bench for bus_arb2 with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arb2;

    localparam int c_mw = 0;
    localparam int c_iw = 2;
    localparam int c_sw = 0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_wen = 1'b0, m1_wen = 1'b0;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic [31:0] m_rdata, bus_addr, bus_wdata;
    logic        bus_wen;
    logic [31:0] bus_rdata = '0;
    logic        cs_mem, cs_simif;
    logic [15:0] cs_io;
    logic        grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_arb2 #(
        .MEM_ADDR_SIZE (32),
        .DATA_W        (32),
        .MEM_WAIT      (c_mw),
        .IO_WAIT       (c_iw),
        .SIMIF_WAIT    (c_sw)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wen    (m0_wen),
        .m0_ready  (m0_ready),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wen    (m1_wen),
        .m1_ready  (m1_ready),
        .m1_err    (m1_err),
        .m_rdata   (m_rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wen   (bus_wen),
        .bus_rdata (bus_rdata),
        .cs_mem    (cs_mem),
        .cs_io     (cs_io),
        .cs_simif  (cs_simif),
        .grant     (grant)
    );

    // Address map of the system decoder: mem 0x0000-0x3FFF, 16 IO blocks of
    // 2 KiB from 0x8000, simif 0xFF00-0xFFFF overlapping IO block 15.
    function automatic logic [17:0] decode_cs(input logic [31:0] a);
        logic [15:0] io;
        io = '0;
        if (a[31:15] == 17'h1)
            io[a[14:11]] = 1'b1;
        return {a[31:8] == 24'h0000FF, io, a < 32'h4000};
    endfunction

    assign {cs_simif, cs_io, cs_mem} = decode_cs(bus_addr);

    // Wait states of the region an address falls in, -1 when unmapped.
    function automatic int region_wait(input logic [31:0] a);
        if (a >= 32'hFF00 && a <= 32'hFFFF) return c_sw;
        if (a >= 32'h8000 && a <= 32'hFFFF) return c_iw;
        if (a < 32'h4000)                   return c_mw;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: a cycle is accepted when idle, completes 2+W clocks
    // later, and the clock after completion is always idle again.
    bit          md_busy   = 0;
    int          md_rem    = 0;
    int          md_last   = 1;
    int          md_master = 0;
    bit          md_err    = 0;
    bit          md_wen    = 0;
    logic [31:0] md_addr   = '0;
    logic [31:0] md_wdata  = '0;

    always @(posedge clk or negedge reset_n) begin
        int w;
        if (!reset_n) begin
            md_busy = 0; md_rem = 0; md_last = 1; md_master = 0;
            md_err = 0; md_wen = 0; md_addr = '0; md_wdata = '0;
        end else if (!md_busy) begin
            if (m0_req || m1_req) begin
                md_master = (m0_req && m1_req) ? 1 - md_last : (m1_req ? 1 : 0);
                md_last   = md_master;
                md_addr   = md_master == 1 ? m1_addr  : m0_addr;
                md_wdata  = md_master == 1 ? m1_wdata : m0_wdata;
                md_wen    = md_master == 1 ? m1_wen   : m0_wen;
                w         = region_wait(md_addr);
                md_err    = (w < 0);
                md_rem    = 1 + (w < 0 ? 0 : w);
                md_busy   = 1;
            end
        end else if (md_rem == 0) begin
            md_busy = 0;
        end else begin
            md_rem--;
        end
    end

    always @(negedge clk) begin
        bit done;
        done = md_busy && md_rem == 0;
        chk("bus_addr",  bus_addr,  md_addr);
        chk("bus_wdata", bus_wdata, md_wdata);
        chk("grant",     grant,     md_last[0]);
        chk("m0_ready",  m0_ready,  done && !md_err && md_master == 0);
        chk("m1_ready",  m1_ready,  done && !md_err && md_master == 1);
        chk("m0_err",    m0_err,    done &&  md_err && md_master == 0);
        chk("m1_err",    m1_err,    done &&  md_err && md_master == 1);
        chk("bus_wen",   bus_wen,   done && !md_err && md_wen);
        if (done && !md_err && !md_wen)
            chk("m_rdata", m_rdata, bus_rdata);
    end

    // One isolated access from an idle bus; latency counted from the
    // request's IDLE cycle (cycle 0).
    task automatic directed(input string nm, input int m, input logic [31:0] a,
                            input logic [31:0] d, input logic w,
                            input int exp_lat, input logic exp_err);
        int   lat;
        int   wen_cyc;
        logic got_err;
        lat = -1; wen_cyc = 0; got_err = 1'b0;
        if (m == 0) begin m0_req = 1; m0_addr = a; m0_wdata = d; m0_wen = w; end
        else        begin m1_req = 1; m1_addr = a; m1_wdata = d; m1_wen = w; end
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge clk); #1;
            if (n == 1) chk({nm, "_addr_c1"}, bus_addr, a);
            if (bus_wen) wen_cyc = n;
            if (m == 0 ? (m0_ready || m0_err) : (m1_ready || m1_err)) begin
                lat = n;
                got_err = (m == 0) ? m0_err : m1_err;
            end
        end
        m0_req = 0; m1_req = 0;
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_err"}, got_err, exp_err);
        chk({nm, "_wen_cycle"}, wen_cyc, (w && !exp_err) ? exp_lat : 0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: return {18'd0, r[13:0]};
            1: return 32'h8000 + (r % 32'h7F00);
            2: return {24'h0000FF, r[7:0]};
            3: return 32'h4000 + {18'd0, r[13:0]};
            default: return {r[31:17], 1'b1, r[15:0]};
        endcase
    endfunction

    initial begin
        int  owners[4];
        int  seen;
        bit  act0, act1;
        repeat (3) @(negedge clk);
        #1 reset_n = 1;
        @(negedge clk); #1;
        chk("reset_grant", grant, 1'b1);
        chk("reset_bus_addr", bus_addr, 32'h0);

        directed("mem_read",   0, 32'h0000_1000, 32'h0,  1'b0, 2, 1'b0);
        directed("io_write",   1, 32'h0000_D000, 32'h5A, 1'b1, 4, 1'b0);
        directed("unmap_hi",   0, 32'h0001_0000, 32'h0,  1'b0, 2, 1'b1);
        directed("unmap_gap",  0, 32'h0000_5000, 32'h0,  1'b0, 2, 1'b1);
        directed("overlap_wr", 1, 32'h0000_FFFF, 32'h77, 1'b1, 2, 1'b0);

        // Abort an IO write while it is in its wait states.
        m1_req = 1; m1_addr = 32'h0000_D004; m1_wdata = 32'hA5; m1_wen = 1;
        repeat (2) @(negedge clk);
        #1 reset_n = 0;
        #1;
        chk("rst_m1_ready", m1_ready, 1'b0);
        chk("rst_bus_wen",  bus_wen,  1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_grant",    grant,    1'b1);
        m0_req = 1; m0_addr = 32'h0000_0100; m0_wen = 0;
        m1_req = 1; m1_addr = 32'h0000_0200; m1_wen = 0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1;

        // Both requests held high from reset: grants must alternate from m0.
        seen = 0;
        for (int c = 0; c < 40 && seen < 4; c++) begin
            @(negedge clk); #1;
            if (m0_ready) begin owners[seen] = 0; seen++; end
            else if (m1_ready) begin owners[seen] = 1; seen++; end
        end
        chk("contention_count", seen, 4);
        chk("contention_0", owners[0], 0);
        chk("contention_1", owners[1], 1);
        chk("contention_2", owners[2], 0);
        chk("contention_3", owners[3], 1);
        m0_req = 0; m1_req = 0;
        repeat (8) @(negedge clk);
        #1;

        act0 = 0; act1 = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk); #1;
            bus_rdata = $urandom;
            if (act0 && (m0_ready || m0_err)) act0 = 0;
            if (!act0 && $urandom_range(0, 2) == 0) begin
                act0 = 1; m0_addr = rand_addr(); m0_wdata = $urandom; m0_wen = 1'($urandom_range(0, 1));
            end
            if (act1 && (m1_ready || m1_err)) act1 = 0;
            if (!act1 && $urandom_range(0, 2) == 0) begin
                act1 = 1; m1_addr = rand_addr(); m1_wdata = $urandom; m1_wen = 1'($urandom_range(0, 1));
            end
            m0_req = act0;
            m1_req = act1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
